// File: rtl/serial_cmp_pkg.sv
// Shared constants for the bit-serial comparator sequencer: default operand width
// and controller state encoding.
package serial_cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/compare_bit_cell.sv
// One-bit chained magnitude cell: z is 1 when the bits seen so far (LSB-first)
// make x's number greater than y's number.
module compare_bit_cell (
    input  logic x,
    input  logic y,
    input  logic v,
    output logic z
);

    assign z = (x & ~y) | (~(x ^ y) & v);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer that compares two WIDTH-bit operands LSB-first through one compare_bit_cell.
// Optional equality output is built when SERIAL_CMP_EQ_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start; operands latched when start is accepted
// S_SHIFT | one operand bit pair evaluated per clock, chain fed back via v_reg
// S_DONE  | done pulse; gt (and eq) hold the final result
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_CMP_EQ_EN
    output logic             eq,
`endif
    output logic             gt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             v_reg;
    logic             z;

    compare_bit_cell u_cell (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .v (v_reg),
        .z (z)
    );

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Results are captured on the edge that enters S_DONE so they are already
    // valid while done is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            v_reg <= 1'b0;
            gt    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
                        v_reg <= 1'b0;
                        gt    <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    v_reg <= z;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        gt    <= z;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_CMP_EQ_EN
    logic eq_acc;
    logic bit_eq;

    assign bit_eq = ~(a_sh[0] ^ b_sh[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eq_acc <= 1'b0;
            eq     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        eq_acc <= 1'b1;
                        eq     <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    eq_acc <= eq_acc & bit_eq;
                    if (cnt == LAST) begin
                        eq <= eq_acc & bit_eq;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
